// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense stage.
// Contents: FSM state encoding, coin values in 5-cent units, coin_sel encodings,
// and a helper that maps a coin_sel value to its value in 5-cent units.
package vend_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StVend  = 3'd1,
    StCoin  = 3'd2,
    StGap   = 3'd3,
    StClear = 3'd4,
    StHold  = 3'd5,
    StFault = 3'd6
  } state_e;

  // Coin values in 5-cent units, matching the upstream counter's "out".
  localparam int unsigned C5  = 1;
  localparam int unsigned C10 = 2;

  localparam logic COIN_SEL_5  = 1'b0;
  localparam logic COIN_SEL_10 = 1'b1;

  function automatic int unsigned coin_value(input logic sel);
    return (sel == COIN_SEL_10) ? C10 : C5;
  endfunction

endpackage

// File: rtl/vend_hs_timer.sv
// Handshake timeout counter, shared by the product and coin handshakes.
// Ports:
//   clk     rising-edge clock
//   reset   synchronous active-low reset
//   start   clear the count (asserted on the edge that enters a handshake)
//   run     a request is currently high
//   ack     acknowledge for the request currently high
//   expire  count has reached ACK_TIMEOUT-1 while running
module vend_hs_timer #(
  parameter int unsigned TO_W        = 4,
  parameter int unsigned ACK_TIMEOUT = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  input  logic ack,
  output logic expire
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire = run && (cnt_q == TO_W'(ACK_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && !ack && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vend_dispense.sv
// Dispense sequencer downstream of the money-accumulating counter.
// On end_i it releases the product (vend_req/vend_ack), ejects change largest
// coin first (coin_req/coin_sel/coin_ack) with at least one idle cycle between
// coins, pulses counter_clr once, then waits for end_i to drop. A handshake
// left unacknowledged for ACK_TIMEOUT cycles parks the block in a sticky fault.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   end_i, ch_i           counter End and change-owed flags (sampled in idle)
//   change_amt            change owed in 5-cent units (sampled in idle)
//   vend_ack, coin_ack    mechanism acknowledges
//   vend_req, coin_req    held requests; coin_sel: 0 = 5-cent, 1 = 10-cent
//   counter_clr           one-cycle clear pulse to the counter
//   busy, fault           not-idle indicator, sticky timeout flag
module vend_dispense
  import vend_pkg::*;
#(
  parameter int unsigned CHG_W       = 2,
  parameter int unsigned TO_W        = 4,
  parameter int unsigned ACK_TIMEOUT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             end_i,
  input  logic             ch_i,
  input  logic [CHG_W-1:0] change_amt,
  input  logic             vend_ack,
  input  logic             coin_ack,
  output logic             vend_req,
  output logic             coin_req,
  output logic             coin_sel,
  output logic             counter_clr,
  output logic             busy,
  output logic             fault
);

  state_e           state_q, state_d;
  logic [CHG_W-1:0] rem_q, rem_d;

  logic vend_req_q, vend_req_d;
  logic coin_req_q, coin_req_d;
  logic coin_sel_q, coin_sel_d;
  logic clr_q, clr_d;
  logic busy_q, busy_d;
  logic fault_q, fault_d;

  logic tmr_start, tmr_run, tmr_ack, tmr_expire;

  // One timer serves both handshakes; it restarts on every entry to VEND/COIN.
  assign tmr_run   = (state_q == StVend) || (state_q == StCoin);
  assign tmr_ack   = (state_q == StVend) ? vend_ack : coin_ack;
  assign tmr_start = (state_d != state_q) && ((state_d == StVend) || (state_d == StCoin));

  vend_hs_timer #(
    .TO_W        (TO_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (tmr_start),
    .run    (tmr_run),
    .ack    (tmr_ack),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (end_i) begin
          rem_d   = ch_i ? change_amt : '0;
          state_d = StVend;
        end
      end
      StVend: begin
        // Ack beats a same-cycle timeout expiry.
        if (vend_ack) begin
          state_d = (rem_q != '0) ? StCoin : StClear;
        end else if (tmr_expire) begin
          state_d = StFault;
        end
      end
      StCoin: begin
        if (coin_ack) begin
          rem_d   = rem_q - CHG_W'(coin_value(coin_sel_q));
          state_d = StGap;
        end else if (tmr_expire) begin
          state_d = StFault;
        end
      end
      StGap: begin
        state_d = (rem_q != '0) ? StCoin : StClear;
      end
      StClear: begin
        state_d = StHold;
      end
      StHold: begin
        // A stale end_i must fall before another vend can start.
        if (!end_i) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered images of the next state; rem only changes on a coin
  // ack edge, which also leaves COIN, so coin_sel is stable while coin_req is high.
  always_comb begin
    vend_req_d = (state_d == StVend);
    coin_req_d = (state_d == StCoin);
    coin_sel_d = ((state_d == StCoin) && (rem_d >= CHG_W'(C10))) ? COIN_SEL_10 : COIN_SEL_5;
    clr_d      = (state_d == StClear);
    busy_d     = (state_d != StIdle);
    fault_d    = (state_d == StFault);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      vend_req_q <= 1'b0;
      coin_req_q <= 1'b0;
      coin_sel_q <= 1'b0;
      clr_q      <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      vend_req_q <= vend_req_d;
      coin_req_q <= coin_req_d;
      coin_sel_q <= coin_sel_d;
      clr_q      <= clr_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
    end
  end

  assign vend_req    = vend_req_q;
  assign coin_req    = coin_req_q;
  assign coin_sel    = coin_sel_q;
  assign counter_clr = clr_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_vend_dispense.sv
// Directed bench for vend_dispense. Output vector order:
// {vend_req, coin_req, coin_sel, counter_clr, busy, fault}.
module tb_vend_dispense;

  localparam int unsigned CHG_W       = 2;
  localparam int unsigned TO_W        = 4;
  localparam int unsigned ACK_TIMEOUT = 12;

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_VEND  = 6'b100010;
  localparam logic [5:0] O_C10   = 6'b011010;
  localparam logic [5:0] O_C5    = 6'b010010;
  localparam logic [5:0] O_BUSY  = 6'b000010;
  localparam logic [5:0] O_CLR   = 6'b000110;
  localparam logic [5:0] O_FAULT = 6'b000011;

  logic             clk;
  logic             reset;
  logic             end_i;
  logic             ch_i;
  logic [CHG_W-1:0] change_amt;
  logic             vend_ack;
  logic             coin_ack;
  logic             vend_req;
  logic             coin_req;
  logic             coin_sel;
  logic             counter_clr;
  logic             busy;
  logic             fault;

  int checks = 0;
  int errors = 0;

  vend_dispense #(
    .CHG_W       (CHG_W),
    .TO_W        (TO_W),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .end_i       (end_i),
    .ch_i        (ch_i),
    .change_amt  (change_amt),
    .vend_ack    (vend_ack),
    .coin_ack    (coin_ack),
    .vend_req    (vend_req),
    .coin_req    (coin_req),
    .coin_sel    (coin_sel),
    .counter_clr (counter_clr),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs driven here are seen at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {vend_req, coin_req, coin_sel, counter_clr, busy, fault};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    reset      = 1'b0;
    end_i      = 1'b0;
    ch_i       = 1'b0;
    change_amt = '0;
    vend_ack   = 1'b0;
    coin_ack   = 1'b0;
    step();
    step();
    chk("reset_state", O_IDLE);
    reset = 1'b1;
    step();
    chk("idle_after_reset", O_IDLE);

    // Exact payment: change_amt ignored because ch_i=0.
    end_i = 1'b1; ch_i = 1'b0; change_amt = 2'd3;
    step(); chk("exact_vend_req", O_VEND);
    step(); chk("exact_vend_hold", O_VEND);
    vend_ack = 1'b1;
    step(); chk("exact_clear", O_CLR);
    vend_ack = 1'b0;
    step(); chk("exact_hold", O_BUSY);
    end_i = 1'b0;
    step(); chk("exact_idle", O_IDLE);

    // Change 3: 10-cent then 5-cent; inputs changed mid-transaction are ignored.
    end_i = 1'b1; ch_i = 1'b1; change_amt = 2'd3;
    step(); chk("chg3_vend", O_VEND);
    ch_i = 1'b0; change_amt = 2'd0;
    vend_ack = 1'b1;
    step(); chk("chg3_coin10", O_C10);
    vend_ack = 1'b0;
    step(); chk("chg3_coin10_hold", O_C10);
    coin_ack = 1'b1;
    step(); chk("chg3_gap", O_BUSY);
    coin_ack = 1'b0;
    step(); chk("chg3_coin5", O_C5);
    step(); chk("chg3_coin5_hold", O_C5);
    coin_ack = 1'b1;
    step(); chk("chg3_gap2", O_BUSY);
    coin_ack = 1'b0;
    step(); chk("chg3_clear", O_CLR);
    step(); chk("chg3_hold", O_BUSY);
    end_i = 1'b0;
    step(); chk("chg3_idle", O_IDLE);

    // Change 1: single 5-cent coin.
    end_i = 1'b1; ch_i = 1'b1; change_amt = 2'd1;
    step(); chk("chg1_vend", O_VEND);
    vend_ack = 1'b1;
    step(); chk("chg1_coin5", O_C5);
    vend_ack = 1'b0; coin_ack = 1'b1;
    step(); chk("chg1_gap", O_BUSY);
    coin_ack = 1'b0;
    step(); chk("chg1_clear", O_CLR);
    end_i = 1'b0;
    step(); chk("chg1_hold", O_BUSY);
    step(); chk("chg1_idle", O_IDLE);

    // Change 2: single 10-cent coin; cross acks are ignored.
    end_i = 1'b1; ch_i = 1'b1; change_amt = 2'd2; coin_ack = 1'b1;
    step(); chk("chg2_vend", O_VEND);
    step(); chk("chg2_coin_ack_in_vend", O_VEND);
    coin_ack = 1'b0; vend_ack = 1'b1;
    step(); chk("chg2_coin10", O_C10);
    step(); chk("chg2_vend_ack_in_coin", O_C10);
    vend_ack = 1'b0; coin_ack = 1'b1;
    step(); chk("chg2_gap", O_BUSY);
    coin_ack = 1'b0;
    step(); chk("chg2_clear", O_CLR);
    end_i = 1'b0;
    step(); chk("chg2_hold", O_BUSY);
    step(); chk("chg2_idle", O_IDLE);

    // Ack on the expiry cycle wins over the timeout.
    end_i = 1'b1; ch_i = 1'b0;
    step(); chk("race_vend", O_VEND);
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
      step(); chk("race_vend_wait", O_VEND);
    end
    vend_ack = 1'b1;
    step(); chk("race_ack_wins", O_CLR);
    vend_ack = 1'b0; end_i = 1'b0;
    step(); chk("race_hold", O_BUSY);
    step(); chk("race_idle", O_IDLE);

    // Coin timeout: coin_req stays up ACK_TIMEOUT cycles, then sticky fault.
    end_i = 1'b1; ch_i = 1'b1; change_amt = 2'd1;
    step(); chk("to_vend", O_VEND);
    vend_ack = 1'b1;
    step(); chk("to_coin", O_C5);
    vend_ack = 1'b0; end_i = 1'b0;
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) begin
      step(); chk("to_coin_wait", O_C5);
    end
    step(); chk("to_fault", O_FAULT);
    step(); chk("to_fault_stay", O_FAULT);
    coin_ack = 1'b1; vend_ack = 1'b1;
    step(); chk("to_fault_acks", O_FAULT);
    coin_ack = 1'b0; vend_ack = 1'b0;
    reset = 1'b0;
    step(); chk("to_reset", O_IDLE);
    reset = 1'b1;
    step(); chk("to_after_reset", O_IDLE);

    // Reset mid-handshake drops vend_req; later acks do nothing.
    end_i = 1'b1; ch_i = 1'b0;
    step(); chk("mid_vend", O_VEND);
    reset = 1'b0;
    step(); chk("mid_reset", O_IDLE);
    reset = 1'b1; end_i = 1'b0; vend_ack = 1'b1;
    step(); chk("mid_ack_ignored", O_IDLE);
    step(); chk("mid_ack_ignored2", O_IDLE);
    vend_ack = 1'b0;

    // Stale end_i after CLEAR cannot retrigger.
    end_i = 1'b1; ch_i = 1'b0;
    step(); chk("stale_vend", O_VEND);
    vend_ack = 1'b1;
    step(); chk("stale_clear", O_CLR);
    vend_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk("stale_hold", O_BUSY);
    end
    end_i = 1'b0;
    step(); chk("stale_idle", O_IDLE);
    end_i = 1'b1;
    step(); chk("stale_revend", O_VEND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
